// File: rtl/alu_pkg.sv
// Shared encodings, saturation constants and FSM state type for the
// nibble-serial saturating ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_PADDSB = 2'b10;

  localparam logic [15:0] SAT16_POS = 16'h7FFF;
  localparam logic [15:0] SAT16_NEG = 16'h8000;
  localparam logic [3:0]  SAT4_POS  = 4'h7;
  localparam logic [3:0]  SAT4_NEG  = 4'h8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/addsub_4bit_cin.sv
// 4-bit add/sub slice with explicit carry-in/out and a signed overflow flag
// computed against the (possibly inverted) B operand.
module addsub_4bit_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       ovf
);

  logic [3:0] bx;
  logic [4:0] c;

  assign bx   = sub ? ~b : b;
  assign c[0] = cin;

  // Explicit ripple so carry timing matches the slice as drawn.
  always_comb begin
    s = '0;
    for (int i = 1; i <= 4; i++) begin
      s[i-1] = a[i-1] ^ bx[i-1] ^ c[i-1];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_carry
    assign c[g+1] = (a[g] & bx[g]) | (a[g] & c[g]) | (bx[g] & c[g]);
  end

  assign cout = c[4];
  assign ovf  = (a[3] == bx[3]) & (a[3] ^ s[3]);

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-cycle 16-bit saturating ADD/SUB/PADDSB built from one 4-bit slice
// reused across the four nibbles; result and flags appear with a done pulse.
module nibble_serial_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [11:0] partial_q;

  logic        is_sub, is_padd;
  logic [3:0]  slc_a, slc_b, slc_s, nib_sat, nib_val;
  logic        slc_cin, slc_cout, slc_ovf;
  logic [15:0] sum16, sat16;

  // Reserved op 11 falls through as ADD since neither decode matches it.
  assign is_sub  = (op_q == OP_SUB);
  assign is_padd = (op_q == OP_PADDSB);

  assign slc_a   = a_q[{idx_q, 2'b00} +: 4];
  assign slc_b   = b_q[{idx_q, 2'b00} +: 4];
  assign slc_cin = is_padd ? 1'b0 : carry_q;

  addsub_4bit_cin u_slice (
    .a    (slc_a),
    .b    (slc_b),
    .sub  (is_sub),
    .cin  (slc_cin),
    .s    (slc_s),
    .cout (slc_cout),
    .ovf  (slc_ovf)
  );

  assign nib_sat = slc_ovf ? (slc_a[3] ? SAT4_NEG : SAT4_POS) : slc_s;
  assign nib_val = is_padd ? nib_sat : slc_s;
  assign sum16   = {slc_s, partial_q};
  assign sat16   = slc_ovf ? (a_q[15] ? SAT16_NEG : SAT16_POS) : sum16;

  assign busy = (state_q == CALC);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (idx_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Partial nibbles shift in from the top so nibble 0 lands at bit 0 after
  // three steps; nibble 3 goes straight into the final result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      partial_q <= '0;
      result    <= '0;
      flag_v    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            idx_q   <= '0;
            carry_q <= (op == OP_SUB);
          end
        end
        CALC: begin
          carry_q   <= slc_cout;
          idx_q     <= idx_q + 2'd1;
          partial_q <= {nib_val, partial_q[11:4]};
          if (idx_q == 2'd3) begin
            done <= 1'b1;
            if (is_padd) begin
              result <= {nib_sat, partial_q};
            end else begin
              result <= sat16;
              flag_v <= slc_ovf;
              flag_z <= (sat16 == 16'h0000);
              flag_n <= sat16[15];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench: issued ops push expected results from an arithmetic
// model; a negedge monitor pops and compares on every done pulse.
module tb_nibble_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] A, B;
  logic        busy, done, flag_v, flag_z, flag_n;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    logic        v, z, n;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mv = 1'b0, mz = 1'b0, mn = 1'b0;

  nibble_serial_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_v (flag_v),
    .flag_z (flag_z),
    .flag_n (flag_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Signed arithmetic with clamping; PADDSB clamps each nibble on its own.
  function automatic exp_t modelOp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   r, na, nb, ns;
    e.res = '0;
    e.due = 0;
    if (o == 2'b10) begin
      for (int i = 0; i < 4; i++) begin
        na = int'($signed(a[4*i +: 4]));
        nb = int'($signed(b[4*i +: 4]));
        ns = na + nb;
        if (ns > 7) ns = 7;
        else if (ns < -8) ns = -8;
        e.res[4*i +: 4] = 4'(ns);
      end
      e.v = mv; e.z = mz; e.n = mn;
    end else begin
      if (o == 2'b01) r = int'($signed(a)) - int'($signed(b));
      else            r = int'($signed(a)) + int'($signed(b));
      e.v = (r > 32767) || (r < -32768);
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      e.res = 16'(r);
      e.z = (e.res == 16'h0000);
      e.n = e.res[15];
      mv = e.v; mz = e.z; mn = e.n;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done got done=1 want done=0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("flag_v", 32'(flag_v), 32'(e.v));
        checkOutput("flag_z", 32'(flag_z), 32'(e.z));
        checkOutput("flag_n", 32'(flag_n), 32'(e.n));
        checkOutput("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait got busy=1 want busy=0 within 20 cycles");
    end
    op = o; A = a; B = b; start = 1'b1;
    e = modelOp(o, a, b);
    e.due = cyc + 5;
    sbq.push_back(e);
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    op = 2'($urandom);
  endtask

  function automatic logic [15:0] pickOperand();
    logic [15:0] edges [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h7F7F};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", 32'({flag_v, flag_z, flag_n}), 32'd0);
    rst_n = 1'b1;

    applyStimulus(2'b00, 16'h1234, 16'h0F0F);
    applyStimulus(2'b00, 16'h7FFF, 16'h0001);
    applyStimulus(2'b00, 16'h8000, 16'hFFFF);
    applyStimulus(2'b10, 16'h7F18, 16'h1178);
    applyStimulus(2'b01, 16'h0005, 16'h0005);
    applyStimulus(2'b01, 16'h8000, 16'h0001);
    applyStimulus(2'b01, 16'h0000, 16'h8000);
    applyStimulus(2'b11, 16'h4000, 16'h4000);
    applyStimulus(2'b10, 16'h8888, 16'hFFFF);

    // start pulsed mid-operation must not spawn a second done
    applyStimulus(2'b00, 16'h0102, 16'h0304);
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 16'hAAAA; B = 16'h5555;
    @(negedge clk);
    start = 1'b0;

    // reset in the second CALC cycle aborts without a done
    applyStimulus(2'b00, 16'h1111, 16'h2222);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    mv = 1'b0; mz = 1'b0; mn = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_flags", 32'({flag_v, flag_z, flag_n}), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(2'b10, 16'h1234, 16'h1111);

    for (int k = 0; k < 150; k++) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
